fpga_config_loader: RTL and testbench



---
 rtl/fpga_config_loader.sv | 130 +++++++++++++
 tb/tb_fpga_config_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_config_loader.sv
// Streaming configuration loader: writes a word stream to an addressed config bus,
// verifies a trailing XOR checksum, and gates fabric_en on a verified image.
module fpga_config_loader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 33,
  parameter int ADDR_W    = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [WORD_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              fabric_en
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [WORD_W-1:0]   r_csum;
  logic                r_in_ready;
  logic                r_cfg_we;
  logic [ADDR_W-1:0]   r_cfg_addr;
  logic [WORD_W-1:0]   r_cfg_data;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_fabric_en;
  logic                w_accept;

  function automatic logic [WORD_W-1:0] fold_xor(input logic [WORD_W-1:0] acc,
                                                 input logic [WORD_W-1:0] word);
    return acc ^ word;
  endfunction

  assign w_accept = in_valid && r_in_ready;

  // Load/check FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_csum      <= '0;
      r_in_ready  <= 1'b0;
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_fabric_en <= 1'b0;
    end else begin
      r_cfg_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_count     <= '0;
            r_csum      <= '0;
            r_busy      <= 1'b1;
            r_in_ready  <= 1'b1;
            r_fabric_en <= 1'b0;
            r_error     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_cfg_we   <= 1'b1;
            r_cfg_addr <= ADDR_W'(r_count);
            r_cfg_data <= in_data;
            r_csum     <= fold_xor(r_csum, in_data);
            r_count    <= r_count + CNT_W'(1);
            if (r_count == LAST_IDX) begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // The checksum word is consumed but never written to the fabric.
          if (w_accept) begin
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_fabric_en <= 1'b1;
            end else begin
              r_state     <= S_ERROR;
              r_error     <= 1'b1;
              r_fabric_en <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_fabric_en <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign cfg_we    = r_cfg_we;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_data  = r_cfg_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign fabric_en = r_fabric_en;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: a vector table on a small 8-bit/4-word instance plus
// multi-cycle sequences on the default 32-bit/33-word instance.
module tb_fpga_config_loader;

  localparam int NUM = 33;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_seen = 0;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] csum_good;

  // default instance
  logic        b_reset, b_start, b_valid;
  logic [31:0] b_data;
  logic        b_in_ready, b_cfg_we, b_busy, b_done, b_error, b_fabric_en;
  logic [5:0]  b_cfg_addr;
  logic [31:0] b_cfg_data;

  fpga_config_loader u_big (
    .clock(clock), .reset(b_reset), .start(b_start), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_in_ready), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
    .busy(b_busy), .done(b_done), .error(b_error), .fabric_en(b_fabric_en)
  );

  // small instance
  logic        s_reset, s_start, s_valid;
  logic [7:0]  s_data;
  logic        s_in_ready, s_cfg_we, s_busy, s_done, s_error, s_fabric_en;
  logic [1:0]  s_cfg_addr;
  logic [7:0]  s_cfg_data;

  fpga_config_loader #(.WORD_W(8), .NUM_WORDS(4), .ADDR_W(2)) u_small (
    .clock(clock), .reset(s_reset), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_in_ready), .cfg_we(s_cfg_we), .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data),
    .busy(s_busy), .done(s_done), .error(s_error), .fabric_en(s_fabric_en)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       vld;
    logic [7:0] d;
    logic       we;
    logic [1:0] addr;
    logic [7:0] cd;
    logic       busy;
    logic       done;
    logic       err;
    logic       fen;
    logic       rdy;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock on the big instance and log what it wrote.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (b_cfg_we) begin
      wr_addr.push_back(b_cfg_addr);
      wr_data.push_back(b_cfg_data);
    end
    if (b_done) done_seen++;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_seen = 0;
  endtask

  task automatic do_start();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  // Stream image words 1..NUM then the checksum; start_at pulses start alongside
  // word index start_at, stop_after abandons the stream after that many words.
  task automatic load_image(input bit bursty, input logic [31:0] csum,
                            input int start_at, input int stop_after);
    int  i = 0;
    int  budget = 0;
    bit  phase = 1'b0;
    bit  acc;
    while (i <= NUM && budget < 400) begin
      if (stop_after >= 0 && i == stop_after) break;
      b_valid = bursty ? ~phase : 1'b1;
      phase   = ~phase;
      b_data  = (i < NUM) ? 32'(i + 1) : csum;
      b_start = (i == start_at);
      acc     = b_valid && b_in_ready;
      tick();
      if (acc) i++;
      budget++;
    end
    b_valid = 1'b0;
    b_start = 1'b0;
    chk("load_budget", 64'(budget < 400), 64'd1);
  endtask

  task automatic check_writes(input string name, input int n);
    chk({name, "_wr_count"}, 64'(wr_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({name, "_wr_addr"}, 64'(wr_addr[i]), 64'(i));
      chk({name, "_wr_data"}, 64'(wr_data[i]), 64'(i + 1));
    end
  endtask

  task automatic chk_big_zero(input string name);
    chk(name, 64'({b_in_ready, b_cfg_we, b_cfg_addr, b_cfg_data, b_busy, b_done,
                   b_error, b_fabric_en}), 64'd0);
  endtask

  initial begin
    int c0;
    b_reset = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 32'd0;
    s_reset = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_data = 8'd0;

    csum_good = 32'd0;
    for (int i = 0; i < NUM; i++) csum_good = csum_good ^ 32'(i + 1);

    //          rst   st    vld   d       we    a     cd      busy  done  err   fen   rdy
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 2'd0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 2'd0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 2'd1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 2'd2, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 2'd0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 2'd1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 2'd2, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[16] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[19] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[20] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[22] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 23; k++) begin
      s_reset = vt[k].rst;
      s_start = vt[k].st;
      s_valid = vt[k].vld;
      s_data  = vt[k].d;
      @(posedge clock);
      #1;
      chk($sformatf("small_vec%0d", k),
          64'({s_cfg_we, s_cfg_addr, s_cfg_data, s_busy, s_done, s_error, s_fabric_en, s_in_ready}),
          64'({vt[k].we, vt[k].addr, vt[k].cd, vt[k].busy, vt[k].done, vt[k].err, vt[k].fen, vt[k].rdy}));
    end
    s_reset = 1'b0; s_start = 1'b0; s_valid = 1'b0;

    tick();
    chk_big_zero("big_reset");
    b_reset = 1'b0;

    // Nominal load: start edge, 33 word edges, checksum edge -> done 34 edges after start.
    clear_log();
    do_start();
    c0 = cyc;
    chk("nom_busy_ready", 64'({b_busy, b_in_ready}), 64'd3);
    load_image(1'b0, csum_good, -1, -1);
    chk("nom_latency", 64'(cyc - c0), 64'd34);
    chk("nom_flags", 64'({b_done, b_fabric_en, b_error, b_busy, b_in_ready}), 64'b11000);
    check_writes("nom", NUM);
    tick();
    chk("nom_after", 64'({b_done, b_fabric_en}), 64'b01);

    // Restart from DONE, then a bursty source.
    clear_log();
    do_start();
    chk("restart_done", 64'({b_fabric_en, b_busy, b_in_ready}), 64'b011);
    load_image(1'b1, csum_good, -1, -1);
    check_writes("burst", NUM);
    chk("burst_done", 64'(done_seen), 64'd1);
    chk("burst_fen", 64'(b_fabric_en), 64'd1);

    // Bad checksum, sticky error, recovery.
    clear_log();
    do_start();
    load_image(1'b0, 32'd0, -1, -1);
    chk("bad_flags", 64'({b_error, b_fabric_en, b_busy}), 64'b100);
    chk("bad_no_done", 64'(done_seen), 64'd0);
    tick();
    tick();
    chk("bad_sticky", 64'({b_error, b_fabric_en}), 64'b10);
    do_start();
    chk("bad_clear", 64'({b_error, b_busy}), 64'b01);
    clear_log();
    load_image(1'b0, csum_good, -1, -1);
    check_writes("reload", NUM);
    chk("reload_fen", 64'({b_fabric_en, b_error}), 64'b10);

    // Start pulsed mid-load is ignored.
    clear_log();
    do_start();
    load_image(1'b0, csum_good, 10, -1);
    check_writes("midstart", NUM);
    chk("midstart_done", 64'({done_seen[1:0], b_fabric_en}), 64'b011);

    // Reset after word 10, then a full reload restarting at address 0.
    do_start();
    clear_log();
    load_image(1'b0, csum_good, -1, 10);
    chk("partial_writes", 64'(wr_addr.size()), 64'd10);
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    chk_big_zero("midload_reset");
    clear_log();
    do_start();
    load_image(1'b0, csum_good, -1, -1);
    check_writes("after_reset", NUM);
    chk("after_reset_fen", 64'({b_fabric_en, b_error}), 64'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
